// File: rtl/exe_pkg.sv
// Shared types and constants for the EXE-stage iterative divider.
// Optional feature macro used by the divider: EXE_DIV_SIGNED_EN.
package exe_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_TAG_W = 4;

  // Quotient returned for a zero divisor.
  localparam logic [DIV_W-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/exe_div_unit_if.sv
// Request/result bundle between the ID/EXE register, hazard logic and the divider.
//
// Handshake: start is a request that the divider accepts on a rising edge only
// when it is idle or presenting a result (busy low); while busy is high start is
// ignored, so upstream must stall on busy. done is a one-cycle strobe with no
// back-pressure; quotient/remainder/rd_out/div_by_zero stay valid after it
// until the next completed operation. flush aborts unconditionally.
interface exe_div_unit_if
  import exe_pkg::*;
#(
  parameter int WIDTH = DIV_W,
  parameter int TAG_W = DIV_TAG_W
) ();

  logic             start;
  logic             flush;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [TAG_W-1:0] rd_in;
  logic             busy;
  logic [TAG_W-1:0] busy_rd;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic [TAG_W-1:0] rd_out;
  logic             div_by_zero;

  modport master (
    output start, flush, is_signed, dividend, divisor, rd_in,
    input  busy, busy_rd, done, quotient, remainder, rd_out, div_by_zero
  );

  modport slave (
    input  start, flush, is_signed, dividend, divisor, rd_in,
    output busy, busy_rd, done, quotient, remainder, rd_out, div_by_zero
  );

endinterface

// File: rtl/exe_div_unit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and keep the difference only
// when it does not go negative. The trial subtract is one bit wider than the
// operands so its top bit is the borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtract and restore decision.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_i};
    if (diff[WIDTH]) begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/exe_div_unit.sv
// EXE-stage iterative radix-2 restoring divider: one quotient bit per cycle,
// MSB first. Holds the destination tag while busy for RAW hazard stalls.
// Optional macro EXE_DIV_SIGNED_EN: honour is_signed (magnitudes are divided,
// then the quotient/remainder signs are fixed up); without it every operation
// is unsigned and no negation logic exists.
module exe_div_unit
  import exe_pkg::*;
#(
  parameter int WIDTH = DIV_W,
  parameter int TAG_W = DIV_TAG_W
) (
  input  logic           clk,
  input  logic           rst_n,
  exe_div_unit_if.slave  bus,
  output div_state_t     dbg_state_o
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [TAG_W-1:0] tag_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic [TAG_W-1:0] rd_out_q;
  logic             dbz_out_q;

  logic             accept, iterate, last;
  logic             dbz_in;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] q_fin, r_fin;

  assign dbz_in = (bus.divisor == '0);

`ifdef EXE_DIV_SIGNED_EN
  logic neg_q_q, neg_r_q;
  logic neg_a_in, neg_b_in;

  // Operand magnitudes; the remainder follows the dividend's sign, the
  // quotient is negated when operand signs differ.
  always_comb begin
    neg_a_in = bus.is_signed & bus.dividend[WIDTH-1];
    neg_b_in = bus.is_signed & bus.divisor[WIDTH-1];
    abs_a    = neg_a_in ? (~bus.dividend + 1'b1) : bus.dividend;
    abs_b    = neg_b_in ? (~bus.divisor + 1'b1) : bus.divisor;
  end

  // Sign fix-up flags captured with the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (accept) begin
      neg_q_q <= neg_a_in ^ neg_b_in;
      neg_r_q <= neg_a_in;
    end
  end

  // Final result with sign fix-up applied to the last iteration's output.
  always_comb begin
    q_fin = neg_q_q ? (~step_quo + 1'b1) : step_quo;
    r_fin = neg_r_q ? (~step_rem + 1'b1) : step_rem;
  end
`else
  assign abs_a = bus.dividend;
  assign abs_b = bus.divisor;
  assign q_fin = step_quo;
  assign r_fin = step_rem;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Next state and per-cycle control; flush overrides everything.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    iterate = 1'b0;
    last    = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = DIV_RUN;
        end
      end
      DIV_RUN: begin
        if (dbz_q || (cnt_q == '0)) begin
          last    = 1'b1;
          state_d = DIV_DONE;
        end else begin
          iterate = 1'b1;
        end
      end
      DIV_DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = DIV_RUN;
        end else begin
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
    if (bus.flush) begin
      state_d = DIV_IDLE;
      accept  = 1'b0;
      iterate = 1'b0;
      last    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DIV_IDLE;
    else        state_q <= state_d;
  end

  // Operand latch on accept, then one shift/subtract per cycle. For a zero
  // divisor the raw dividend is parked in quo_q so it can be returned as the
  // remainder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      tag_q <= '0;
      dbz_q <= 1'b0;
    end else if (accept) begin
      cnt_q <= CNT_LAST;
      rem_q <= '0;
      quo_q <= dbz_in ? bus.dividend : abs_a;
      dvs_q <= abs_b;
      tag_q <= bus.rd_in;
      dbz_q <= dbz_in;
    end else if (iterate) begin
      cnt_q <= cnt_q - 1'b1;
      rem_q <= step_rem;
      quo_q <= step_quo;
    end
  end

  // Result registers, written only on the completing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient_q  <= '0;
      remainder_q <= '0;
      rd_out_q    <= '0;
      dbz_out_q   <= 1'b0;
    end else if (last) begin
      quotient_q  <= dbz_q ? WIDTH'(DIV_ZERO_Q) : q_fin;
      remainder_q <= dbz_q ? quo_q : r_fin;
      rd_out_q    <= tag_q;
      dbz_out_q   <= dbz_q;
    end
  end

  assign bus.busy        = (state_q == DIV_RUN);
  assign bus.busy_rd     = (state_q == DIV_RUN) ? tag_q : '0;
  assign bus.done        = (state_q == DIV_DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.rd_out      = rd_out_q;
  assign bus.div_by_zero = dbz_out_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_exe_div_unit.sv
// Bench for exe_div_unit: vector table plus hand-written multi-cycle sequences
// (ignored start, back-to-back, flush, async reset). Expected results go into
// a queue when an operation is launched and are compared when done strobes.
module tb_exe_div_unit;
  import exe_pkg::*;

  localparam int W     = 32;
  localparam int EXP_W = 32 + 32 + 4 + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [3:0]  rd;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  logic       clk;
  logic       rst_n;
  div_state_t dbg_state;

  exe_div_unit_if bus ();

  exe_div_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  vec_t vecs[$];

  // Clock and reset drive defaults.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("result q", 64'(bus.quotient), 64'(e[68:37]));
        check("result r", 64'(bus.remainder), 64'(e[36:5]));
        check("result rd", 64'(bus.rd_out), 64'(e[4:1]));
        check("result dbz", 64'(bus.div_by_zero), 64'(e[0]));
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [3:0] rd);
    bus.start     = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.is_signed = s;
    bus.rd_in     = rd;
  endtask

  task automatic wait_done(input int l0, output int lat, output int busy_n);
    lat    = l0;
    busy_n = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input vec_t v, input string name);
    int lat, busy_n, exp_lat;
    exp_lat = (v.b == 0) ? 2 : 33;
    @(negedge clk);
    drive(v.a, v.b, v.s, v.rd);
    exp_q.push_back({v.q, v.r, v.rd, v.dbz});
    @(negedge clk);
    bus.start = 1'b0;
    check({name, " busy_rd"}, 64'(bus.busy_rd), 64'(v.rd));
    wait_done(1, lat, busy_n);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " busy cycles"}, 64'(busy_n), 64'(exp_lat - 1));
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, " q/r"}, {bus.quotient, bus.remainder}, 64'd0);
    check({name, " ctrl"}, 64'({bus.busy, bus.busy_rd, bus.done, bus.rd_out, bus.div_by_zero}), 64'd0);
  endtask

  initial begin
    int lat, busy_n, seen;
    vec_t v;
    logic [31:0] ra, rb;

    // Vector table.
    vecs.push_back('{a:32'd100,        b:32'd7,          s:1'b0, rd:4'd5,  q:32'd14,         r:32'd2,          dbz:1'b0});
    vecs.push_back('{a:32'd5,          b:32'd0,          s:1'b0, rd:4'd2,  q:32'hFFFFFFFF,   r:32'd5,          dbz:1'b1});
    vecs.push_back('{a:32'd0,          b:32'd1,          s:1'b0, rd:4'd1,  q:32'd0,          r:32'd0,          dbz:1'b0});
    vecs.push_back('{a:32'hFFFFFFFF,   b:32'd1,          s:1'b0, rd:4'd15, q:32'hFFFFFFFF,   r:32'd0,          dbz:1'b0});
    vecs.push_back('{a:32'hFFFFFFFF,   b:32'hFFFFFFFF,   s:1'b0, rd:4'd4,  q:32'd1,          r:32'd0,          dbz:1'b0});
    vecs.push_back('{a:32'd7,          b:32'd100,        s:1'b0, rd:4'd8,  q:32'd0,          r:32'd7,          dbz:1'b0});
    vecs.push_back('{a:32'hFFFFFFF9,   b:32'd0,          s:1'b1, rd:4'd9,  q:32'hFFFFFFFF,   r:32'hFFFFFFF9,   dbz:1'b1});
`ifdef EXE_DIV_SIGNED_EN
    vecs.push_back('{a:32'hFFFFFFF9,   b:32'd2,          s:1'b1, rd:4'd3,  q:32'hFFFFFFFD,   r:32'hFFFFFFFF,   dbz:1'b0});
    vecs.push_back('{a:32'h80000000,   b:32'hFFFFFFFF,   s:1'b1, rd:4'd6,  q:32'h80000000,   r:32'd0,          dbz:1'b0});
    vecs.push_back('{a:32'd7,          b:32'hFFFFFFFE,   s:1'b1, rd:4'd7,  q:32'hFFFFFFFD,   r:32'd1,          dbz:1'b0});
    vecs.push_back('{a:32'hFFFFFFF9,   b:32'hFFFFFFFE,   s:1'b1, rd:4'd10, q:32'd3,          r:32'hFFFFFFFF,   dbz:1'b0});
`else
    vecs.push_back('{a:32'hFFFFFFF9,   b:32'd2,          s:1'b1, rd:4'd3,  q:32'h7FFFFFFC,   r:32'd1,          dbz:1'b0});
    vecs.push_back('{a:32'h80000000,   b:32'hFFFFFFFF,   s:1'b1, rd:4'd6,  q:32'd0,          r:32'h80000000,   dbz:1'b0});
    vecs.push_back('{a:32'd7,          b:32'hFFFFFFFE,   s:1'b1, rd:4'd7,  q:32'd0,          r:32'd7,          dbz:1'b0});
    vecs.push_back('{a:32'hFFFFFFF9,   b:32'hFFFFFFFE,   s:1'b1, rd:4'd10, q:32'd0,          r:32'hFFFFFFF9,   dbz:1'b0});
`endif
    for (int i = 0; i < 6; i++) begin
      ra = $urandom();
      rb = (i < 3) ? 32'($urandom_range(1, 65535)) : $urandom();
      if (rb == 0) rb = 32'd3;
      vecs.push_back('{a:ra, b:rb, s:1'b0, rd:4'($urandom_range(0, 15)), q:ra / rb, r:ra % rb, dbz:1'b0});
    end

    // Reset.
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.flush     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.rd_in     = '0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    check("reset state", 64'(dbg_state), 64'(DIV_IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven operations.
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Start while running is ignored; busy_rd keeps the first tag.
    @(negedge clk);
    drive(32'd100, 32'd7, 1'b0, 4'd3);
    exp_q.push_back({32'd14, 32'd2, 4'd3, 1'b0});
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    drive(32'd9, 32'd3, 1'b0, 4'd9);
    @(negedge clk);
    bus.start = 1'b0;
    check("ignored start busy_rd", 64'(bus.busy_rd), 64'd3);
    wait_done(11, lat, busy_n);
    check("ignored start latency", 64'(lat), 64'd33);

    // Back-to-back: start during the done cycle.
    drive(32'd9, 32'd3, 1'b0, 4'd6);
    exp_q.push_back({32'd3, 32'd0, 4'd6, 1'b0});
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b busy", 64'(bus.busy), 64'd1);
    check("b2b held q", 64'(bus.quotient), 64'd14);
    wait_done(1, lat, busy_n);
    check("b2b latency", 64'(lat), 64'd33);

    // Flush at cycle 5: no done, results untouched.
    @(negedge clk);
    drive(32'd100, 32'd7, 1'b0, 4'd7);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush busy", 64'(bus.busy), 64'd0);
    check("flush busy_rd", 64'(bus.busy_rd), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    check("flush no activity", 64'(seen), 64'd0);
    check("flush held q", 64'(bus.quotient), 64'd3);

    // Flush beats start.
    drive(32'd50, 32'd5, 1'b0, 4'd2);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush beats start", 64'(bus.busy), 64'd0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    drive(32'd100, 32'd7, 1'b0, 4'd5);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    check("post reset idle", 64'(seen), 64'd0);
    v = '{a:32'd1000, b:32'd33, s:1'b0, rd:4'd11, q:32'd30, r:32'd10, dbz:1'b0};
    run_op(v, "post reset op");

    repeat (3) @(negedge clk);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
